smac_pipe: RTL

Parametrised, precision-configurable sub-MAC for one processing element of the DTPU systolic array. It splits a `DATA_W`-bit word into lanes of 1x, 2x, 4x or 8x `MIN_LANE` bits, selected per operation. Each lane computes a signed multiply-accumulate against the partial sum arriving from the previous row. It forwards the input activation to the next row, delayed to match result latency, and adds valid tracking, clock-enable stall and illegal-precision detection.

---
 rtl/smac_pipe.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/smac_pipe.sv
// smac_pipe: precision-configurable sub-MAC for one systolic-array processing element.
//
// The DATA_W-bit word is split into lanes of MIN_LANE<<k bits (k = 0..3, chosen per
// operation by a one-hot select). Each lane computes r = a*w + c in signed two's
// complement and reduces the result back to the lane width. The activation is forwarded
// to the next row, aligned with the result.
//
// Optional feature macro: SMAC_SAT_EN
//   defined   : lanes saturate to the signed lane range, sat_flag reports clamping
//   undefined : lanes wrap (truncate), sat_flag is tied low
//
// Ports:
//   clk                  clock, all state on rising edge
//   sclr                 synchronous active-high reset (drops in-flight operations)
//   ce                   clock enable, low holds every register
//   in_valid             operands valid this cycle
//   select_precision     one-hot lane width select, bit k -> MIN_LANE<<k
//   data_input           activations, lanes packed LSB-first
//   weight               weights, same packing
//   res_mac_p            partial sums from previous row
//   res_mac_n            per-lane results
//   out_valid            res_mac_n valid
//   data_input_next_row  activation forwarded to next row
//   next_row_valid       qualifies data_input_next_row (equals out_valid)
//   prec_err             sticky illegal-precision flag, cleared only by sclr
//   sat_flag             some lane of the current valid result saturated
module smac_pipe #(
    parameter int DATA_W   = 64,
    parameter int MIN_LANE = 8
) (
    input  logic              clk,
    input  logic              sclr,
    input  logic              ce,
    input  logic              in_valid,
    input  logic [3:0]        select_precision,
    input  logic [DATA_W-1:0] data_input,
    input  logic [DATA_W-1:0] weight,
    input  logic [DATA_W-1:0] res_mac_p,
    output logic [DATA_W-1:0] res_mac_n,
    output logic              out_valid,
    output logic [DATA_W-1:0] data_input_next_row,
    output logic              next_row_valid,
    output logic              prec_err,
    output logic              sat_flag
);

    // S1: operand register. Operands are captured on every enabled cycle; only
    // vld_p0 qualifies them, so the data registers carry no reset.
    logic [DATA_W-1:0] a_p0, w_p0, c_p0;
    logic [3:0]        sel_p0;
    logic              vld_p0;

    always_ff @(posedge clk) begin
        if (ce) begin
            a_p0   <= data_input;
            w_p0   <= weight;
            c_p0   <= res_mac_p;
            sel_p0 <= select_precision;
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            vld_p0 <= 1'b0;
        end else if (ce) begin
            vld_p0 <= in_valid;
        end
    end

    // Lane arithmetic for all four widths in parallel; the latched select picks one.
    logic [3:0][DATA_W-1:0] mode_res;

`ifdef SMAC_SAT_EN
    localparam int SUMW = 2 * DATA_W + 1;

    // Returns {above max, below min} for a full-precision sum against an l-bit range.
    function automatic logic [1:0] sat_dir(input logic signed [SUMW-1:0] v, input int l);
        logic signed [SUMW-1:0] hi, lo;
        hi = (SUMW'(1) <<< (l - 1)) - SUMW'(1);
        lo = -hi - SUMW'(1);
        return {v > hi, v < lo};
    endfunction

    logic [3:0] mode_sat;
`endif

    for (genvar k = 0; k < 4; k++) begin : g_mode
        localparam int L = MIN_LANE << k;
        localparam int N = DATA_W / L;
`ifdef SMAC_SAT_EN
        logic [N-1:0] lane_sat;
        assign mode_sat[k] = |lane_sat;
`endif
        for (genvar i = 0; i < N; i++) begin : g_lane
            logic signed [L-1:0] a, w, c;
            assign a = a_p0[i*L +: L];
            assign w = w_p0[i*L +: L];
            assign c = c_p0[i*L +: L];
`ifdef SMAC_SAT_EN
            logic signed [2*L-1:0]  prod;
            logic signed [2*L:0]    sum;
            logic signed [SUMW-1:0] sum_x;
            logic [1:0]             dir;
            assign prod  = a * w;
            // One extra bit keeps the full product plus sign-extended c exact.
            assign sum   = {prod[2*L-1], prod} + {{(L+1){c[L-1]}}, c};
            assign sum_x = SUMW'(sum);
            assign dir   = sat_dir(sum_x, L);
            assign lane_sat[i] = |dir;
            assign mode_res[k][i*L +: L] = dir[1] ? {1'b0, {(L-1){1'b1}}} :
                                           dir[0] ? {1'b1, {(L-1){1'b0}}} :
                                                    sum[L-1:0];
`else
            // Wrap mode only needs the low L bits of the product and sum.
            logic signed [L-1:0] prod;
            assign prod = a * w;
            assign mode_res[k][i*L +: L] = prod + c;
`endif
        end
    end

    logic              sel_ok;
    logic [1:0]        k_sel;
    logic [DATA_W-1:0] res_sel;
    logic              sat_sel;

    always_comb begin
        sel_ok  = 1'b1;
        k_sel   = 2'd0;
        res_sel = '0;
        sat_sel = 1'b0;
        case (sel_p0)
            4'b0001: k_sel = 2'd0;
            4'b0010: k_sel = 2'd1;
            4'b0100: k_sel = 2'd2;
            4'b1000: k_sel = 2'd3;
            default: sel_ok = 1'b0;
        endcase
        if (sel_ok) begin
            res_sel = mode_res[k_sel];
`ifdef SMAC_SAT_EN
            sat_sel = mode_sat[k_sel];
`endif
        end
    end

    // S2: result register. Illegal selects produce a zero result but still
    // advance the valid bit, and latch the sticky error.
    logic vld_p1;
    logic sat_p1;

    always_ff @(posedge clk) begin
        if (sclr) begin
            res_mac_n           <= '0;
            data_input_next_row <= '0;
            vld_p1              <= 1'b0;
            prec_err            <= 1'b0;
            sat_p1              <= 1'b0;
        end else if (ce) begin
            res_mac_n           <= res_sel;
            data_input_next_row <= a_p0;
            vld_p1              <= vld_p0;
            sat_p1              <= vld_p0 & sat_sel;
            if (vld_p0 && !sel_ok) begin
                prec_err <= 1'b1;
            end
        end
    end

    assign out_valid      = vld_p1;
    assign next_row_valid = vld_p1;
`ifdef SMAC_SAT_EN
    assign sat_flag = sat_p1;
`else
    assign sat_flag = 1'b0;
`endif

endmodule
